// File: rtl/sad_accumulator_pkg.sv
// Shared constants for the AbsDiff family:
// FSM state encodings and default sizes.
package sad_accumulator_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int DEF_SIZE  = 8;
  localparam int DEF_COUNT = 4;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nBitAdder.sv
// Ripple adder built from 2-bit slices.
// Ports: a, b, carryIn -> sum, carryOut.
module nBitAdder #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            carryIn,
  output logic [SIZE-1:0] sum,
  output logic            carryOut
);

  localparam int NS = SIZE / 2;

  logic [NS:0] c;

  assign c[0] = carryIn;

  for (genvar i = 0; i < NS; i++) begin : g_slice
    logic [2:0] s;
    assign s = {1'b0, a[2*i+1:2*i]}
             + {1'b0, b[2*i+1:2*i]}
             + {2'b00, c[i]};
    assign sum[2*i+1:2*i] = s[1:0];
    assign c[i+1]         = s[2];
  end

  assign carryOut = c[NS];

endmodule

// File: rtl/sad_accumulator_abs.sv
// |a-b| as diff plus a deferred +1 (inc).
// Ports: a, b -> diff, inc.
module abs_diff_unit #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic [SIZE-1:0] diff,
  output logic            inc
);

  logic [SIZE-1:0] sum;
  logic            co;

  nBitAdder #(.SIZE(SIZE)) u_add (
    .a        (a),
    .b        (~b),
    .carryIn  (1'b0),
    .sum      (sum),
    .carryOut (co)
  );

  // co=1: a>b, sum=a-b-1, needs +1
  // co=0: a<=b, ~sum = b-a exactly
  always_comb begin
    diff = co ? sum : ~sum;
    inc  = co;
  end

endmodule

// File: rtl/sad_accumulator.sv
// SAD stage: sums |a-b| over COUNT pairs.
// start/in_* feed pairs, out_*/sad return result.
module sad_accumulator
  import sad_accumulator_pkg::*;
#(
  parameter int SIZE  = DEF_SIZE,
  parameter int COUNT = DEF_COUNT,
  parameter int ACC_W = SIZE + $clog2(COUNT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIZE-1:0]  a,
  input  logic [SIZE-1:0]  b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sad,
  output logic             busy
);

  localparam int CNT_W = cnt_width(COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(COUNT - 1);

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [SIZE-1:0]  diff;
  logic             inc;
  logic             xfer;

  abs_diff_unit #(.SIZE(SIZE)) u_abs (
    .a    (a),
    .b    (b),
    .diff (diff),
    .inc  (inc)
  );

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = in_ready | out_valid;
  assign sad       = acc_q;
  assign xfer      = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (xfer) begin
          // correction enters as the carry
          acc_d = acc_q + ACC_W'(diff)
                + ACC_W'(inc);
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST)
            state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sad_accumulator.sv
// Directed bench for sad_accumulator:
// 8-bit/4-pair instance plus 2-bit/1-pair.
module tb_sad_accumulator;

  logic       clk;
  logic       rst_n;

  logic       start, in_valid, out_ready;
  logic [7:0] a, b;
  logic       in_ready, out_valid, busy;
  logic [9:0] sad;

  logic       start1, in_valid1, out_ready1;
  logic [1:0] a1, b1;
  logic       in_ready1, out_valid1, busy1;
  logic [1:0] sad1;

  int n_chk;
  int n_err;

  sad_accumulator #(.SIZE(8), .COUNT(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sad       (sad),
    .busy      (busy)
  );

  sad_accumulator #(.SIZE(2), .COUNT(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start1),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .sad       (sad1),
    .busy      (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] pa,
                      input logic [7:0] pb);
    a        = pa;
    b        = pb;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1);
  end

  initial begin
    n_chk      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    a          = '0;
    b          = '0;
    start1     = 1'b0;
    in_valid1  = 1'b0;
    out_ready1 = 1'b0;
    a1         = '0;
    b1         = '0;

    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sad", sad, 0);
    chk("rst_busy", busy, 0);
    #10;
    rst_n = 1'b1;
    step();
    chk("idle_in_ready", in_ready, 0);

    // frame 1: back-to-back pairs
    pulse_start();
    chk("f1_in_ready", in_ready, 1);
    chk("f1_busy", busy, 1);
    send(8'd10, 8'd3);
    send(8'd3, 8'd10);
    send(8'd7, 8'd7);
    chk("f1_not_done", out_valid, 0);
    send(8'd255, 8'd0);
    chk("f1_out_valid", out_valid, 1);
    chk("f1_in_ready0", in_ready, 0);
    chk("f1_sad", sad, 269);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("f1_idle_ov", out_valid, 0);
    chk("f1_idle_busy", busy, 0);

    // frame 2: two idle cycles mid-frame
    pulse_start();
    send(8'd10, 8'd3);
    send(8'd3, 8'd10);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("f2_gap_cnt", u_dut.cnt_q, 2);
      chk("f2_gap_ov", out_valid, 0);
      chk("f2_gap_ir", in_ready, 1);
    end
    send(8'd7, 8'd7);
    chk("f2_not_done", out_valid, 0);
    send(8'd255, 8'd0);
    chk("f2_out_valid", out_valid, 1);
    chk("f2_sad", sad, 269);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // frame 3: worst case, then hold result
    pulse_start();
    for (int i = 0; i < 4; i++)
      send(8'd0, 8'd255);
    chk("f3_sad", sad, 1020);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) start = 1'b1;
      step();
      start = 1'b0;
      chk("hold_ov", out_valid, 1);
      chk("hold_sad", sad, 1020);
      chk("hold_ir", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("hold_busy", busy, 0);
    chk("hold_ov0", out_valid, 0);
    step();
    chk("hold_stay_idle", busy, 0);

    // frame 4: async reset mid-frame
    pulse_start();
    send(8'd9, 8'd1);
    send(8'd9, 8'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_ir", in_ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_sad", sad, 0);
    chk("arst_ov", out_valid, 0);
    #2;
    rst_n = 1'b1;
    step();
    chk("arst_wait", in_ready, 0);
    pulse_start();
    for (int i = 0; i < 4; i++)
      send(8'd1, 8'd0);
    chk("arst_ov1", out_valid, 1);
    chk("arst_sad4", sad, 4);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // COUNT=1, SIZE=2 instance
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("c1_ir", in_ready1, 1);
    a1        = 2'd0;
    b1        = 2'd3;
    in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    chk("c1_ov", out_valid1, 1);
    chk("c1_sad", sad1, 3);
    out_ready1 = 1'b1;
    step();
    out_ready1 = 1'b0;
    chk("c1_busy", busy1, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sad_accumulator.md
# sad_accumulator

Sequential sum-of-absolute-differences (SAD) stage. It accepts a stream of operand pairs (A, B) and forms |A−B| for each pair with one `nBitAdder` instance. It accumulates COUNT such differences and presents the total through a valid/ready output. It sits directly on the output side of the n-bit adder, consuming its `sum`/`carryOut` to build the absolute-difference datapath.

## Interface
- SIZE, 8, operand width; must be even and ≥ 2 (the adder is built from 2-bit slices)
- COUNT, 4, pairs per SAD result; ≥ 1
- ACC_W, SIZE + clog2(COUNT), accumulator and result width; cannot overflow
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins a new SAD frame; ignored unless in IDLE
- in_valid  input  1  operand pair valid
- in_ready  output  1  stage accepts a pair this cycle
- a  input  SIZE  unsigned operand A
- b  input  SIZE  unsigned operand B
- out_valid  output  1  `sad` holds a completed result
- out_ready  input  1  consumer takes the result
- sad  output  ACC_W  sum of |a−b| over the frame
- busy  output  1  high in ACCUM or DONE

## Operation
- Absolute difference, combinational:
  - The adder is fed `a` and `~b`; its carry-in is fixed at 0, so sum = a − b − 1 (mod 2^SIZE).
  - If carryOut = 1, then a > b and diff = sum + 1.
  - If carryOut = 0, then a ≤ b and diff = ~sum, which equals b − a; a = b gives 0.
- The +1 correction is applied as the carry into the accumulator add. No second SIZE-bit incrementer.
- FSM states: IDLE, ACCUM, DONE.
  - IDLE: in_ready = 0, out_valid = 0. On start: acc ← 0, cnt ← 0, go to ACCUM.
  - ACCUM: in_ready = 1. A transfer is in_valid && in_ready. On each transfer: acc ← acc + zero-extended diff, cnt ← cnt + 1.
    - On the transfer where cnt = COUNT−1: go to DONE, latching the final acc (including that pair).
    - Cycles with in_valid = 0 change nothing.
  - DONE: out_valid = 1, sad = acc, held stable until taken. On out_ready: go to IDLE.
- start in ACCUM or DONE is ignored. It does not restart the frame or drop the pending result.
- cnt width is clog2(COUNT), minimum 1 bit. For COUNT = 1, the first transfer goes straight to DONE.
- No overflow check is required: ACC_W ≥ SIZE + clog2(COUNT) bounds the worst case COUNT·(2^SIZE−1).

## Timing
- Reset (rst_n = 0, asynchronous):
  - State IDLE; acc = 0, cnt = 0.
  - Outputs: in_ready = 0, out_valid = 0, sad = 0, busy = 0.
- Reset asserted mid-frame discards the partial sum immediately. After release the block waits for a new start.
- start at edge k → in_ready = 1 from cycle k+1.
- Throughput in ACCUM: one pair per cycle.
- Last transfer at edge k → out_valid = 1 and sad valid at cycle k+1.
- out_ready = 1 in the first DONE cycle → IDLE next cycle. The minimum DONE duration is one cycle.
- out_ready while not in DONE has no effect.
- Frame latency with in_valid held high: COUNT + 2 cycles from start to IDLE.
- in_ready and out_valid are registered-state decodes with no combinational path from in_valid or out_ready.
- a and b only need to be stable when in_valid is high.

## Structure
- Constants shared with other AbsDiff blocks go in one shared include: state encodings (IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2) and the default SIZE/COUNT.
- Sub-module: one `nBitAdder #(.SIZE(SIZE))` instance for the subtract. The accumulator add, counter and FSM are local.
- Optional local helper `abs_diff_unit`, wrapping the adder and the invert/select logic, producing `diff` and `inc`.

## Test plan
- SIZE = 8, COUNT = 4; pairs (10,3), (3,10), (7,7), (255,0) with in_valid held high -> out_valid 1 cycle after the 4th transfer, sad = 7+7+0+255 = 269.
- Same frame with in_valid low for 2 cycles between pairs 2 and 3 -> sad = 269, out_valid delayed exactly 2 cycles, cnt unchanged during the gaps.
- COUNT = 4, all pairs (0,255) -> sad = 1020, no wrap (ACC_W = 10).
- Result pending with out_ready = 0 for 5 cycles, start pulsed meanwhile -> sad and out_valid stable, start ignored; out_ready = 1 -> IDLE next cycle, busy = 0.
- rst_n pulsed low after 2 transfers -> all outputs reset asynchronously, before the next edge. New start then 4 pairs of (1,0) -> sad = 4.
- COUNT = 1, SIZE = 2, pair (0,3) -> DONE after the single transfer, sad = 3.
